// File: rtl/gamerom_loader.sv
// -----------------------------------------------------------------------------
// gamerom_loader
//   Streams a cartridge image from the host byte channel into the game ROM
//   write port, one byte per accepted beat. It checks the MSX "AB" header,
//   pads short images with PAD_BYTE, discards bytes beyond ROM_BYTES and keeps
//   the Z80 held off the ROM while a load is in progress.
//
// Ports
//   clk_i        system clock
//   reset_i      asynchronous, active-high reset
//   start_i      one-cycle pulse that begins a load (ignored unless idle)
//   s_data_i     stream byte
//   s_valid_i    stream byte valid
//   s_last_i     final byte of the image (qualified by s_valid_i)
//   s_ready_o    loader accepts s_data_i this cycle (registered, state only)
//   we_b_o       ROM write strobe (registered)
//   addr_b_o     ROM write address (registered)
//   din_b_o      ROM write data (registered)
//   cpu_hold_o   keep the Z80 in reset / off the ROM
//   busy_o       load in progress
//   done_o       one-cycle pulse at the end of a load
//   error_o      header mismatch or overflow, sticky until the next start
//   checksum_o   mod-256 sum of stream bytes written to the ROM
//
// State   | meaning
// --------+----------------------------------------------------------------
// S_IDLE  | waiting for start
// S_LOAD  | accepting stream bytes and writing them to the ROM
// S_FILL  | stream ended early, writing PAD_BYTE up to the last address
// S_DRAIN | header error or overflow, swallowing bytes until s_last
// S_FIN   | single cycle before done pulses and the CPU is released
// -----------------------------------------------------------------------------
module gamerom_loader #(
   parameter int unsigned ROM_BYTES = 16384,
   parameter int unsigned ADDR_W    = 16,
   parameter bit          HDR_CHECK = 1'b1,
   parameter logic [7:0]  PAD_BYTE  = 8'hFF
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [7:0]        s_data_i,
   input  logic              s_valid_i,
   input  logic              s_last_i,
   output logic              s_ready_o,
   output logic              we_b_o,
   output logic [ADDR_W-1:0] addr_b_o,
   output logic [7:0]        din_b_o,
   output logic              cpu_hold_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic [7:0]        checksum_o
);

   // One extra bit so the counter can reach ROM_BYTES without wrapping.
   localparam int unsigned      CNT_W    = $clog2(ROM_BYTES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROM_BYTES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_FILL  = 3'd2,
      S_DRAIN = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        din_q, din_d;
   logic              err_q, err_d;
   logic [7:0]        ck_q, ck_d;
   logic              rdy_q, rdy_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic accept;
   logic hdr_bad;

   assign accept = s_valid_i & rdy_q;

   // Header bytes are still written to the ROM; a mismatch only flags the load.
   always_comb begin
      hdr_bad = 1'b0;
      if (HDR_CHECK) begin
         hdr_bad = ((cnt_q == '0)     && (s_data_i != 8'h41)) ||
                   ((cnt_q == CNT_ONE) && (s_data_i != 8'h42));
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      din_d   = din_q;
      err_d   = err_q;
      ck_d    = ck_q;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_LOAD;
               cnt_d   = '0;
               err_d   = 1'b0;
               ck_d    = '0;
            end
         end

         S_LOAD: begin
            if (accept) begin
               we_d   = 1'b1;
               addr_d = ADDR_W'(cnt_q);
               din_d  = s_data_i;
               cnt_d  = cnt_q + CNT_ONE;
               ck_d   = ck_q + s_data_i;
               if (hdr_bad) begin
                  // A bad header that is also the last byte needs no drain.
                  err_d   = 1'b1;
                  state_d = s_last_i ? S_FIN : S_DRAIN;
               end else if (cnt_q == CNT_LAST) begin
                  if (s_last_i) begin
                     state_d = S_FIN;
                  end else begin
                     err_d   = 1'b1;
                     state_d = S_DRAIN;
                  end
               end else if (s_last_i) begin
                  state_d = S_FILL;
               end
            end
         end

         S_FILL: begin
            we_d   = 1'b1;
            addr_d = ADDR_W'(cnt_q);
            din_d  = PAD_BYTE;
            cnt_d  = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d = S_FIN;
            end
         end

         S_DRAIN: begin
            if (accept && s_last_i) begin
               state_d = S_FIN;
            end
         end

         S_FIN: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status flags follow the next state so they line up with state_q.
      // busy/cpu_hold span FIN, so they drop on the same edge done rises.
      rdy_d  = (state_d == S_LOAD) || (state_d == S_DRAIN);
      busy_d = (state_d == S_LOAD) || (state_d == S_FILL) ||
               (state_d == S_DRAIN) || (state_d == S_FIN);
      done_d = (state_q == S_FIN);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         err_q   <= 1'b0;
         ck_q    <= '0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         err_q   <= err_d;
         ck_q    <= ck_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign s_ready_o  = rdy_q;
   assign we_b_o     = we_q;
   assign addr_b_o   = addr_q;
   assign din_b_o    = din_q;
   assign cpu_hold_o = busy_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign error_o    = err_q;
   assign checksum_o = ck_q;

endmodule
